matvec_out_requant: RTL and testbench

//  Downstream stage of matvec3_part1. Consumes its 28-bit signed result stream (valid/ready).

---
 rtl/matvec_pkg.sv | 28 ++
 rtl/matvec_sat_round.sv | 56 +++++
 rtl/matvec_out_requant.sv | 130 +++++++++++++
 tb/tb_matvec_out_requant.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matvec output requantization stage.
// Optional build macro: MATVEC_REQUANT_RELU_EN (see matvec_sat_round.sv).
package matvec_pkg;

    localparam int IN_W  = 28;
    localparam int OUT_W = 14;

    typedef logic signed [IN_W-1:0]  result_t;
    typedef logic signed [OUT_W-1:0] qdata_t;

    typedef struct packed {
        qdata_t data;
        logic   last;
        logic   sat;
    } qentry_t;

    // Saturating 16-bit increment: sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/matvec_sat_round.sv
// Combinational rescale: round-half-up arithmetic right shift followed by a
// signed clamp to OUT_W bits.
// With MATVEC_REQUANT_RELU_EN defined, negative rounded values become 0 before
// the clamp and never raise the saturation flag.
module matvec_sat_round
    import matvec_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic signed [IN_W-1:0]  x_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    // One extra bit so the rounding add can never overflow.
    localparam int EXT_W = IN_W + 1;
    localparam int RND_POS = (SHIFT > 0) ? (SHIFT - 1) : 0;
    localparam logic signed [EXT_W-1:0] RND =
        (SHIFT > 0) ? (EXT_W'(1) << RND_POS) : EXT_W'(0);
    localparam logic signed [EXT_W-1:0] QMAX = EXT_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] QMIN = EXT_W'(-(1 <<< (OUT_W - 1)));

    logic signed [EXT_W-1:0] sum_s;
    logic signed [EXT_W-1:0] shr_s;
    logic signed [EXT_W-1:0] relu_s;
    logic signed [EXT_W-1:0] clamp_s;

    // Round, shift, optional ReLU, then clamp and flag any clamp that changed the value.
    always_comb begin
        sum_s   = $signed({x_i[IN_W-1], x_i}) + RND;
        shr_s   = sum_s >>> SHIFT;
`ifdef MATVEC_REQUANT_RELU_EN
        if (shr_s[EXT_W-1]) begin
            relu_s = '0;
        end else begin
            relu_s = shr_s;
        end
`else
        relu_s = shr_s;
`endif
        sat_o   = 1'b0;
        clamp_s = relu_s;
        if (relu_s > QMAX) begin
            clamp_s = QMAX;
            sat_o   = 1'b1;
        end else if (relu_s < QMIN) begin
            clamp_s = QMIN;
            sat_o   = 1'b1;
        end else begin
            clamp_s = relu_s;
            sat_o   = 1'b0;
        end
        data_o = clamp_s[OUT_W-1:0];
    end

endmodule

// File: rtl/matvec_out_requant.sv
// Output stage behind matvec3_part1: requantizes each 28-bit result to 14 bits,
// buffers it in a DEPTH-entry circular FIFO, tags the last element of each
// K-element vector and counts saturated samples.
// Optional build macro: MATVEC_REQUANT_RELU_EN (ReLU before the clamp).
module matvec_out_requant
    import matvec_pkg::*;
#(
    parameter int K     = 3,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic signed [IN_W-1:0]  input_data,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic signed [OUT_W-1:0] output_data,
    output logic                    output_last,
    output logic                    output_sat,
    output logic [15:0]             sat_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ELEM_W = (K > 1) ? $clog2(K) : 1;

    qentry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ELEM_W-1:0]  elem_q, elem_d;
    logic [15:0]        sat_count_q, sat_count_d;

    qdata_t             rq_data_s;
    logic               rq_sat_s;
    qentry_t            entry_s;
    qentry_t            head_s;
    logic               push_s;
    logic               pop_s;

    matvec_sat_round #(
        .SHIFT (SHIFT)
    ) u_sat_round (
        .x_i    (input_data),
        .data_o (rq_data_s),
        .sat_o  (rq_sat_s)
    );

    // Handshake and head-of-FIFO output view; everything here comes from registers or reset.
    always_comb begin
        input_ready  = !reset && (count_q != CNT_W'(DEPTH));
        output_valid = (count_q != CNT_W'(0));
        push_s       = input_valid && input_ready;
        pop_s        = output_valid && output_ready;
        entry_s.data = rq_data_s;
        entry_s.sat  = rq_sat_s;
        entry_s.last = (elem_q == ELEM_W'(K - 1));
        head_s       = mem_q[rd_ptr_q];
        output_data  = head_s.data;
        output_last  = head_s.last;
        output_sat   = head_s.sat;
        sat_count    = sat_count_q;
    end

    // Next-state for pointers, occupancy, element index and saturation counter.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        elem_d      = elem_q;
        sat_count_d = sat_count_q;

        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
            elem_d   = (elem_q == ELEM_W'(K - 1)) ? ELEM_W'(0) : elem_q + ELEM_W'(1);
            if (rq_sat_s) begin
                sat_count_d = sat_inc16(sat_count_q);
            end else begin
                sat_count_d = sat_count_q;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
            elem_d   = elem_q;
        end

        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A simultaneous push and pop leaves occupancy unchanged.
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset discards any buffered partial vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            elem_q      <= '0;
            sat_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            elem_q      <= elem_d;
            sat_count_q <= sat_count_d;
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as all zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end
    end

endmodule

// File: tb/tb_matvec_out_requant.sv
// Self-checking bench for matvec_out_requant (K=3, SHIFT=8, DEPTH=4).
// A queue-based reference model is updated every falling edge; directed
// literal checks pin the model's arithmetic and framing.
module tb_matvec_out_requant;

    localparam int K     = 3;
    localparam int SHIFT = 8;
    localparam int DEPTH = 4;

    logic                clk;
    logic                reset;
    logic                input_valid;
    logic                input_ready;
    logic signed [27:0]  input_data;
    logic                output_valid;
    logic                output_ready;
    logic signed [13:0]  output_data;
    logic                output_last;
    logic                output_sat;
    logic [15:0]         sat_count;

    int vectors;
    int miscompares;

    typedef struct {
        longint data;
        bit     last;
        bit     sat;
    } exp_t;

    exp_t   mq[$];
    int     m_elem;
    longint m_satcnt;

    matvec_out_requant #(.K(K), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_last  (output_last),
        .output_sat   (output_sat),
        .sat_count    (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    // Reference arithmetic: round half up, divide by 2^SHIFT, clamp to 14 bits.
    function automatic void requant(input longint x, output longint d, output bit s);
        longint t;
        t = floor_div(x + (longint'(1) << (SHIFT - 1)), longint'(1) << SHIFT);
`ifdef MATVEC_REQUANT_RELU_EN
        if (t < 0) t = 0;
`endif
        s = 1'b0;
        if (t > 8191) begin t = 8191; s = 1'b1; end
        else if (t < -8192) begin t = -8192; s = 1'b1; end
        d = t;
    endfunction

    // Compare process: checks DUT against the model, then advances the model
    // with the transfers that the coming rising edge will perform.
    always @(negedge clk) begin
        exp_t e;
        bit   pop, push;
        if (reset) begin
            check("rst_out_valid", output_valid, 0);
            check("rst_in_ready", input_ready, 0);
            check("rst_out_data", output_data, 0);
            check("rst_out_last", output_last, 0);
            check("rst_out_sat", output_sat, 0);
            check("rst_sat_count", sat_count, 0);
            mq.delete();
            m_elem   = 0;
            m_satcnt = 0;
        end else begin
            check("out_valid", output_valid, (mq.size() != 0));
            check("in_ready", input_ready, (mq.size() != DEPTH));
            check("sat_count", sat_count, m_satcnt);
            if (output_valid && mq.size() != 0) begin
                check("out_data", output_data, mq[0].data);
                check("out_last", output_last, mq[0].last);
                check("out_sat", output_sat, mq[0].sat);
            end
            pop  = output_valid && output_ready;
            push = input_valid && input_ready;
            if (pop && mq.size() != 0) void'(mq.pop_front());
            if (push) begin
                requant(longint'(input_data), e.data, e.sat);
                e.last = (m_elem == K - 1);
                m_elem = (m_elem + 1) % K;
                if (e.sat && m_satcnt != 65535) m_satcnt++;
                mq.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one value into an empty FIFO, check the literal result, then pop it.
    task automatic single(input longint x, input longint ed, input longint es, input longint esc);
        input_valid = 1'b1;
        input_data  = 28'(x);
        tick();
        input_valid = 1'b0;
        @(negedge clk);
        check("lit_data", output_data, ed);
        check("lit_sat", output_sat, es);
        check("lit_sat_count", sat_count, esc);
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;
    endtask

    task automatic drain();
        output_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!output_valid) break;
            tick();
        end
        output_ready = 1'b0;
        check("drain_empty", output_valid, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int acc, pops;
        logic [6:0] lastmask;
        logic [2:0] lastmask3;

        vectors      = 0;
        miscompares  = 0;
        input_valid  = 1'b0;
        output_ready = 1'b0;
        input_data   = '0;
        reset        = 1'b1;
        m_elem       = 0;
        m_satcnt     = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Rounding and saturation literals.
        single(384, 2, 0, 0);
`ifdef MATVEC_REQUANT_RELU_EN
        single(-384, 0, 0, 0);
`else
        single(-384, -1, 0, 0);
`endif
        single(127, 0, 0, 0);
        single(128, 1, 0, 0);
        single(2097152, 8191, 1, 1);
`ifdef MATVEC_REQUANT_RELU_EN
        single(-2097152, 0, 0, 1);
        single(-2097152 - 129, 0, 0, 1);
`else
        single(-2097152, -8192, 0, 1);
        single(-2097152 - 129, -8192, 1, 2);
`endif

        // Backpressure: six offers with the sink stalled.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            input_valid = 1'b1;
            input_data  = 28'(1000 * (i + 1));
            @(negedge clk);
            if (input_valid && input_ready) acc++;
            tick();
        end
        input_valid = 1'b0;
        check("bp_accepts", acc, 4);
        check("bp_in_ready", input_ready, 0);
        drain();

        // Framing with random stalls from a clean vector boundary.
        do_reset();
        acc = 0;
        pops = 0;
        lastmask = '0;
        for (int cyc = 0; cyc < 300 && pops < 7; cyc++) begin
            input_valid  = (acc < 7) && ($urandom_range(0, 2) != 0);
            input_data   = 28'($urandom);
            output_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (input_valid && input_ready) acc++;
            if (output_valid && output_ready) begin
                lastmask[pops] = output_last;
                pops++;
            end
            tick();
        end
        input_valid  = 1'b0;
        output_ready = 1'b0;
        check("frame_accepts", acc, 7);
        check("frame_pops", pops, 7);
        check("frame_lastmask", lastmask, 7'b0100100);

        // Throughput with both sides always willing.
        acc = 0;
        pops = 0;
        input_valid  = 1'b1;
        output_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            input_data = 28'(i * 4099 - 150000);
            @(negedge clk);
            if (i > 0) check("tp_valid", output_valid, 1);
            if (input_valid && input_ready) acc++;
            if (output_valid && output_ready) pops++;
            tick();
        end
        input_valid = 1'b0;
        check("tp_accepts", acc, 100);
        check("tp_pops", pops, 99);
        drain();

        // Reset in the middle of a vector.
        input_valid = 1'b1;
        input_data  = 28'(5000);
        tick();
        input_data  = 28'(6000);
        tick();
        input_valid  = 1'b0;
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", output_valid, 0);
        check("midrst_in_ready", input_ready, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            input_valid = 1'b1;
            input_data  = 28'(256 * (i + 1));
            tick();
        end
        input_valid = 1'b0;
        pops = 0;
        lastmask3 = '0;
        output_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && pops < 3; cyc++) begin
            @(negedge clk);
            if (output_valid && output_ready) begin
                lastmask3[pops] = output_last;
                pops++;
            end
            tick();
        end
        output_ready = 1'b0;
        check("midrst_pops", pops, 3);
        check("midrst_lastmask", lastmask3, 3'b100);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
